// File: rtl/axi_mst_outstanding_ctrl.sv
// AXI master-side outstanding-transaction limiter. It counts issued AW/AR requests against
// retired B/R-last responses, gates new issues at the limit, and runs a drain handshake.
module axi_mst_outstanding_ctrl #(
  parameter int AW_PL_W    = 48,
  parameter int AR_PL_W    = 48,
  parameter int MAX_WR_OUT = 8,
  parameter int MAX_RD_OUT = 8,
  parameter int CNT_W      = $clog2(((MAX_WR_OUT > MAX_RD_OUT) ? MAX_WR_OUT : MAX_RD_OUT) + 1)
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               s_awvalid,
  output logic               s_awready,
  input  logic [AW_PL_W-1:0] s_awpayload,
  output logic               m_awvalid,
  input  logic               m_awready,
  output logic [AW_PL_W-1:0] m_awpayload,
  input  logic               s_arvalid,
  output logic               s_arready,
  input  logic [AR_PL_W-1:0] s_arpayload,
  output logic               m_arvalid,
  input  logic               m_arready,
  output logic [AR_PL_W-1:0] m_arpayload,
  input  logic               bvalid,
  input  logic               bready,
  input  logic               rvalid,
  input  logic               rready,
  input  logic               rlast,
  input  logic               drain_req,
  output logic               drain_ack,
  output logic [CNT_W-1:0]   wr_outstanding,
  output logic [CNT_W-1:0]   rd_outstanding,
  output logic               err_underflow,
  input  logic               err_clr
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAINING = 2'd1,
    ST_DRAINED  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] WR_MAX = CNT_W'(MAX_WR_OUT);
  localparam logic [CNT_W-1:0] RD_MAX = CNT_W'(MAX_RD_OUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
  logic               err_q, err_d;
  logic               drain_ack_q, drain_ack_d;

  logic               wr_block_s, rd_block_s;
  logic               wr_issue_s, wr_retire_s, rd_issue_s, rd_retire_s;
  logic               wr_uf_s, rd_uf_s;

  // A retire at zero without a matching issue is an underflow and leaves the count at zero.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic issue,
                                                input logic retire);
    logic [CNT_W-1:0] nxt;
    case ({issue, retire})
      2'b10:   nxt = cnt + CNT_W'(1);
      2'b01:   nxt = (cnt == '0) ? cnt : cnt - CNT_W'(1);
      default: nxt = cnt;
    endcase
    return nxt;
  endfunction

  assign m_awpayload = s_awpayload;
  assign m_arpayload = s_arpayload;

  assign wr_block_s = (wr_cnt_q == WR_MAX) | (state_q != ST_RUN);
  assign rd_block_s = (rd_cnt_q == RD_MAX) | (state_q != ST_RUN);

  // ARESETn term keeps both handshake directions quiet while reset is held.
  assign m_awvalid = s_awvalid & ~wr_block_s & ARESETn;
  assign s_awready = m_awready & ~wr_block_s & ARESETn;
  assign m_arvalid = s_arvalid & ~rd_block_s & ARESETn;
  assign s_arready = m_arready & ~rd_block_s & ARESETn;

  assign wr_issue_s  = m_awvalid & m_awready;
  assign wr_retire_s = bvalid & bready;
  assign rd_issue_s  = m_arvalid & m_arready;
  assign rd_retire_s = rvalid & rready & rlast;

  assign wr_uf_s = wr_retire_s & ~wr_issue_s & (wr_cnt_q == '0);
  assign rd_uf_s = rd_retire_s & ~rd_issue_s & (rd_cnt_q == '0);

  // Next-state for counters, sticky error and the drain FSM.
  always_comb begin
    wr_cnt_d = cnt_next(wr_cnt_q, wr_issue_s, wr_retire_s);
    rd_cnt_d = cnt_next(rd_cnt_q, rd_issue_s, rd_retire_s);

    if (wr_uf_s || rd_uf_s) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end

    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (drain_req) begin
          state_d = ST_DRAINING;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAINING: begin
        // Completion looks at next-state counts so ack follows the final retire by one cycle.
        if (!drain_req) begin
          state_d = ST_RUN;
        end else if ((wr_cnt_d == '0) && (rd_cnt_d == '0)) begin
          state_d = ST_DRAINED;
        end else begin
          state_d = ST_DRAINING;
        end
      end
      ST_DRAINED: begin
        if (!drain_req) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DRAINED;
        end
      end
      default: state_d = ST_RUN;
    endcase

    drain_ack_d = (state_d == ST_DRAINED);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= ST_RUN;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      err_q       <= 1'b0;
      drain_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      err_q       <= err_d;
      drain_ack_q <= drain_ack_d;
    end
  end

  assign wr_outstanding = wr_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign err_underflow  = err_q;
  assign drain_ack      = drain_ack_q;

endmodule

// File: tb/tb_axi_mst_outstanding_ctrl.sv
// Directed bench: instance A (limits 2/2) and instance B (limits 4/4) share all inputs.
module tb_axi_mst_outstanding_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        s_awvalid = 1'b0, m_awready = 1'b0, s_arvalid = 1'b0, m_arready = 1'b0;
  logic        bvalid = 1'b0, bready = 1'b0, rvalid = 1'b0, rready = 1'b0, rlast = 1'b0;
  logic        drain_req = 1'b0, err_clr = 1'b0;
  logic [47:0] s_awpayload = 48'd0, s_arpayload = 48'd0;

  logic        a_awready, a_awvalid, a_arready, a_arvalid, a_ack, a_err;
  logic [47:0] a_awpl, a_arpl;
  logic [1:0]  a_wr, a_rd;
  logic        b_awready, b_awvalid, b_arready, b_arvalid, b_ack, b_err;
  logic [47:0] b_awpl, b_arpl;
  logic [2:0]  b_wr, b_rd;

  int vectors = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  axi_mst_outstanding_ctrl #(.AW_PL_W(48), .AR_PL_W(48), .MAX_WR_OUT(2), .MAX_RD_OUT(2)) dut_a (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awvalid(s_awvalid), .s_awready(a_awready), .s_awpayload(s_awpayload),
    .m_awvalid(a_awvalid), .m_awready(m_awready), .m_awpayload(a_awpl),
    .s_arvalid(s_arvalid), .s_arready(a_arready), .s_arpayload(s_arpayload),
    .m_arvalid(a_arvalid), .m_arready(m_arready), .m_arpayload(a_arpl),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .drain_req(drain_req), .drain_ack(a_ack),
    .wr_outstanding(a_wr), .rd_outstanding(a_rd),
    .err_underflow(a_err), .err_clr(err_clr)
  );

  axi_mst_outstanding_ctrl #(.AW_PL_W(48), .AR_PL_W(48), .MAX_WR_OUT(4), .MAX_RD_OUT(4)) dut_b (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_awvalid(s_awvalid), .s_awready(b_awready), .s_awpayload(s_awpayload),
    .m_awvalid(b_awvalid), .m_awready(m_awready), .m_awpayload(b_awpl),
    .s_arvalid(s_arvalid), .s_arready(b_arready), .s_arpayload(s_arpayload),
    .m_arvalid(b_arvalid), .m_arready(m_arready), .m_arpayload(b_arpl),
    .bvalid(bvalid), .bready(bready), .rvalid(rvalid), .rready(rready), .rlast(rlast),
    .drain_req(drain_req), .drain_ack(b_ack),
    .wr_outstanding(b_wr), .rd_outstanding(b_rd),
    .err_underflow(b_err), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    ARESETn = 1'b0;
    #3;
    ARESETn = 1'b1;
  endtask

  initial begin
    // Reset state with handshake inputs driven high
    s_awvalid = 1'b1; m_awready = 1'b1; s_arvalid = 1'b1; m_arready = 1'b1;
    #2;
    chk("rst_a_wr", 64'(a_wr), 64'd0);
    chk("rst_a_rd", 64'(a_rd), 64'd0);
    chk("rst_a_err", 64'(a_err), 64'd0);
    chk("rst_a_ack", 64'(a_ack), 64'd0);
    chk("rst_m_awvalid", 64'(a_awvalid), 64'd0);
    chk("rst_s_awready", 64'(a_awready), 64'd0);
    chk("rst_m_arvalid", 64'(a_arvalid), 64'd0);
    chk("rst_s_arready", 64'(a_arready), 64'd0);
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    tick();
    ARESETn = 1'b1;
    tick();

    // Payload pass-through
    s_awpayload = 48'h1234_5678_9ABC;
    s_arpayload = 48'hFEDC_BA98_7654;
    #1;
    chk("aw_payload", 64'(a_awpl), 64'h1234_5678_9ABC);
    chk("ar_payload", 64'(b_arpl), 64'hFEDC_BA98_7654);

    // Write limit on A (MAX 2)
    s_awvalid = 1'b1;
    #1;
    chk("lim_awvalid0", 64'(a_awvalid), 64'd1);
    tick();
    chk("lim_wr1", 64'(a_wr), 64'd1);
    tick();
    chk("lim_wr2", 64'(a_wr), 64'd2);
    chk("lim_awready_blk", 64'(a_awready), 64'd0);
    chk("lim_awvalid_blk", 64'(a_awvalid), 64'd0);
    chk("lim_b_wr2", 64'(b_wr), 64'd2);
    tick();
    chk("lim_wr2_hold", 64'(a_wr), 64'd2);
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    #1;
    chk("lim_wr_after_b", 64'(a_wr), 64'd1);
    chk("lim_third_ready", 64'(a_awready), 64'd1);
    tick();
    chk("lim_wr_third", 64'(a_wr), 64'd2);
    s_awvalid = 1'b0;

    // Simultaneous issue and retire holds the count
    do_reset();
    s_awvalid = 1'b1;
    tick();
    tick();
    s_awvalid = 1'b1; bvalid = 1'b1; bready = 1'b1;
    #1;
    chk("sim_b_awvalid", 64'(b_awvalid), 64'd1);
    tick();
    s_awvalid = 1'b0; bvalid = 1'b0; bready = 1'b0;
    chk("sim_b_wr_hold", 64'(b_wr), 64'd2);
    chk("sim_b_err", 64'(b_err), 64'd0);

    // Read burst: one AR, four R beats, rlast only on the fourth
    do_reset();
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    chk("rd_after_ar", 64'(a_rd), 64'd1);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b0;
    tick();
    chk("rd_beat1", 64'(a_rd), 64'd1);
    tick();
    chk("rd_beat2", 64'(a_rd), 64'd1);
    tick();
    chk("rd_beat3", 64'(a_rd), 64'd1);
    rlast = 1'b1;
    tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    chk("rd_beat4", 64'(a_rd), 64'd0);
    chk("rd_no_err", 64'(a_err), 64'd0);

    // Underflow detection, stickiness and clear
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    chk("uf_err_set", 64'(a_err), 64'd1);
    chk("uf_wr_zero", 64'(a_wr), 64'd0);
    tick();
    chk("uf_sticky", 64'(a_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("uf_cleared", 64'(a_err), 64'd0);
    bvalid = 1'b1; bready = 1'b1; s_awvalid = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0; s_awvalid = 1'b0;
    chk("uf_simul_noerr", 64'(a_err), 64'd0);
    chk("uf_simul_wr0", 64'(a_wr), 64'd0);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1; err_clr = 1'b1;
    tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0; err_clr = 1'b0;
    chk("uf_rd_set_wins", 64'(a_err), 64'd1);
    chk("uf_rd_zero", 64'(a_rd), 64'd0);

    // Drain flow
    do_reset();
    chk("drain_rst_err", 64'(a_err), 64'd0);
    s_awvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
    drain_req = 1'b1;
    #1;
    chk("drain_rise_accept", 64'(a_awvalid), 64'd1);
    tick();
    s_arvalid = 1'b1;
    #1;
    chk("drain_wr2", 64'(a_wr), 64'd2);
    chk("drain_aw_blk", 64'(a_awvalid), 64'd0);
    chk("drain_awready_blk", 64'(a_awready), 64'd0);
    chk("drain_ar_blk", 64'(a_arvalid), 64'd0);
    chk("drain_arready_blk", 64'(a_arready), 64'd0);
    bvalid = 1'b1; bready = 1'b1;
    tick();
    tick();
    bvalid = 1'b0; bready = 1'b0;
    chk("drain_wr0", 64'(a_wr), 64'd0);
    chk("drain_ack_wait_rd", 64'(a_ack), 64'd0);
    rvalid = 1'b1; rready = 1'b1; rlast = 1'b1;
    tick();
    rvalid = 1'b0; rready = 1'b0; rlast = 1'b0;
    chk("drain_rd0", 64'(a_rd), 64'd0);
    chk("drain_ack", 64'(a_ack), 64'd1);
    chk("drain_hold_blk", 64'(a_awvalid), 64'd0);
    drain_req = 1'b0;
    tick();
    chk("drain_ack_drop", 64'(a_ack), 64'd0);
    chk("resume_aw", 64'(a_awvalid), 64'd1);
    chk("resume_ar", 64'(a_arvalid), 64'd1);
    s_awvalid = 1'b0; s_arvalid = 1'b0;

    // Asynchronous reset mid-operation on B (limits 4/4)
    do_reset();
    bvalid = 1'b1; bready = 1'b1;
    tick();
    bvalid = 1'b0; bready = 1'b0;
    s_awvalid = 1'b1; s_arvalid = 1'b1;
    tick();
    tick();
    s_arvalid = 1'b0;
    tick();
    chk("mid_b_wr3", 64'(b_wr), 64'd3);
    chk("mid_b_rd2", 64'(b_rd), 64'd2);
    chk("mid_b_err", 64'(b_err), 64'd1);
    #2;
    ARESETn = 1'b0;
    #1;
    chk("async_b_wr", 64'(b_wr), 64'd0);
    chk("async_b_rd", 64'(b_rd), 64'd0);
    chk("async_b_err", 64'(b_err), 64'd0);
    chk("async_b_ack", 64'(b_ack), 64'd0);
    chk("async_b_awvalid", 64'(b_awvalid), 64'd0);
    chk("async_b_awready", 64'(b_awready), 64'd0);
    s_awvalid = 1'b0;
    #3;
    ARESETn = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_mst_outstanding_ctrl.md
AXI_MST_OUTSTANDING_CTRL -- requirements
Module: axi_mst_outstanding_ctrl

Interface
REQ-001 SHALL have parameter AW_PL_W, default 48: width of the bundled AW payload (addr, id, len, size, burst).
REQ-002 SHALL have parameter AR_PL_W, default 48: width of the bundled AR payload.
REQ-003 SHALL have parameter MAX_WR_OUT, default 8: maximum outstanding writes, legal range 1..255.
REQ-004 SHALL have parameter MAX_RD_OUT, default 8: maximum outstanding reads, legal range 1..255.
REQ-005 SHALL have derived parameter CNT_W = clog2(max(MAX_WR_OUT, MAX_RD_OUT) + 1).
REQ-006 SHALL have port ACLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port ARESETn, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have ports s_awvalid (in, 1), s_awready (out, 1) and s_awpayload (in, AW_PL_W): AW channel from the master.
REQ-009 SHALL have ports m_awvalid (out, 1), m_awready (in, 1) and m_awpayload (out, AW_PL_W): AW channel toward the NOC.
REQ-010 SHALL have ports s_arvalid (in, 1), s_arready (out, 1) and s_arpayload (in, AR_PL_W): AR channel from the master.
REQ-011 SHALL have ports m_arvalid (out, 1), m_arready (in, 1) and m_arpayload (out, AR_PL_W): AR channel toward the NOC.
REQ-012 SHALL have ports bvalid, bready, rvalid, rready and rlast, all input, 1 bit: monitored response handshakes, not driven by this block.
REQ-013 SHALL have port drain_req, input, 1 bit: a level request to stop issuing and drain outstanding traffic.
REQ-014 SHALL have port drain_ack, output, 1 bit: asserted when drained.
REQ-015 SHALL have ports wr_outstanding and rd_outstanding, output, CNT_W bits each: the current outstanding counts.
REQ-016 SHALL have port err_underflow, output, 1 bit: sticky flag for a response received with no outstanding transaction.
REQ-017 SHALL have port err_clr, input, 1 bit: synchronous clear of err_underflow.

Function
REQ-018 SHALL pass payloads combinationally: m_awpayload = s_awpayload and m_arpayload = s_arpayload.
REQ-019 SHALL compute wr_block = (wr_outstanding == MAX_WR_OUT) | (state != RUN), and rd_block likewise using MAX_RD_OUT; both use registered counts only.
REQ-020 SHALL drive m_awvalid = s_awvalid & ~wr_block and s_awready = m_awready & ~wr_block; the AR channel is identical using rd_block.
REQ-021 SHALL define wr_issue = m_awvalid & m_awready and wr_retire = bvalid & bready.
REQ-022 SHALL define rd_issue = m_arvalid & m_arready and rd_retire = rvalid & rready & rlast.
REQ-023 SHALL update each counter next cycle as follows: issue only increments by 1; retire only decrements by 1; issue and retire together hold the count; neither holds the count.
REQ-024 SHALL, on retire with count 0 and no issue in the same cycle, hold the count at 0 and set err_underflow the next cycle.
REQ-025 SHALL, on retire with count 0 and issue in the same cycle, treat it as simultaneous: count stays 0 and no error is flagged.
REQ-026 SHALL never increment a counter past its MAX; this is guaranteed by REQ-019.
REQ-027 SHALL clear err_underflow on err_clr; if err_clr and a new underflow occur in the same cycle, the set wins.
REQ-028 SHALL implement an FSM with states RUN, DRAINING and DRAINED.
REQ-029 SHALL transition RUN -> DRAINING when drain_req = 1.
REQ-030 SHALL transition DRAINING -> DRAINED when both counters are 0, evaluated on next-state counts.
REQ-031 SHALL transition DRAINING -> RUN when drain_req = 0 before draining completes.
REQ-032 SHALL transition DRAINED -> RUN when drain_req = 0.
REQ-033 SHALL drive drain_ack = 1 only in state DRAINED, from a register.
REQ-034 SHALL take effect of drain_req on issue gating one cycle after drain_req rises, once the FSM leaves RUN.
REQ-035 SHALL NOT drop a handshake already accepted in the cycle drain_req rises.

Reset
REQ-036 SHALL, while ARESETn = 0, asynchronously force: state = RUN, wr_outstanding = 0, rd_outstanding = 0, err_underflow = 0, drain_ack = 0.
REQ-037 SHALL, while reset is asserted, hold m_awvalid, m_arvalid, s_awready and s_arready at 0 regardless of inputs.
REQ-038 SHALL, on reset mid-operation, discard all counts; traffic still in flight is not tracked after reset release.

Verification
REQ-039 SHALL cover the write limit: MAX_WR_OUT = 2, three back-to-back AWs with m_awready = 1 and no B -> two handshakes, third blocked with s_awready = 0, wr_outstanding = 2; one B -> third issues the next cycle.
REQ-040 SHALL cover simultaneous issue and retire: wr_outstanding = 2, AW handshake and B in the same cycle -> count stays 2, no stall at MAX if under the limit.
REQ-041 SHALL cover read burst counting: AR len = 3, four R beats with rlast on the 4th only -> rd_outstanding goes 1 -> 1 -> 1 -> 0.
REQ-042 SHALL cover underflow: B with count 0 -> err_underflow = 1 the next cycle and count stays 0; err_clr -> 0; B and AW in the same cycle at count 0 -> no error.
REQ-043 SHALL cover the drain flow: counts wr = 1 and rd = 1, drain_req = 1 -> new AW and AR blocked; B then R-last -> drain_ack = 1 the cycle after the last retire; drain_req = 0 -> RUN, issue resumes.
REQ-044 SHALL cover reset mid-operation: counts 3/2 with err set, ARESETn pulsed low asynchronously -> all outputs at reset values immediately, with no clock edge required.
